sc_psrandom_lfsr: RTL and testbench

//   Pseudo-random generator stage fed by the load-control state machine. Consumes its active-low one-cycle

---
 rtl/sc_psrandom_pkg.sv | 14 +
 rtl/sc_psrandom_lfsr_if.sv | 28 ++
 rtl/sc_psrandom_lfsr_step.sv | 16 +
 rtl/sc_psrandom_lfsr.sv | 82 ++++++++
 tb/tb_sc_psrandom_lfsr.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sc_psrandom_pkg.sv
// Shared defaults and FSM encoding for the pseudo-random generator stage.
package sc_psrandom_pkg;

  localparam int unsigned DATAWIDTH_DEF  = 8;
  localparam int unsigned COUNTWIDTH_DEF = 8;
  localparam logic [7:0]  TAPS_DEF       = 8'hB8;
  localparam logic [7:0]  SEED_DEF       = 8'h01;

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_SEEDED   = 1'b1
  } state_e;

endpackage

// File: rtl/sc_psrandom_lfsr_if.sv
// Strobe/seed inputs and capture outputs between the load-control FSM and the LFSR stage.
interface sc_psrandom_lfsr_if
  import sc_psrandom_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DATAWIDTH_DEF,
  parameter int unsigned COUNTWIDTH = COUNTWIDTH_DEF
);

  logic                  loadseed_InLow;
  logic                  loadrand_InLow;
  logic                  run_InHigh;
  logic [DATAWIDTH-1:0]  seed_InBUS;
  logic [DATAWIDTH-1:0]  random_OutBUS;
  logic                  valid_OutHigh;
  logic                  seeded_OutHigh;
  logic [COUNTWIDTH-1:0] count_OutBUS;

  modport master (
    output loadseed_InLow, loadrand_InLow, run_InHigh, seed_InBUS,
    input  random_OutBUS, valid_OutHigh, seeded_OutHigh, count_OutBUS
  );

  modport slave (
    input  loadseed_InLow, loadrand_InLow, run_InHigh, seed_InBUS,
    output random_OutBUS, valid_OutHigh, seeded_OutHigh, count_OutBUS
  );

endinterface

// File: rtl/sc_psrandom_lfsr_step.sv
// One step of a right-shifting Galois LFSR; purely combinational.
module sc_psrandom_lfsr_step
  import sc_psrandom_pkg::*;
#(
  parameter int unsigned          DATAWIDTH = DATAWIDTH_DEF,
  parameter logic [DATAWIDTH-1:0] TAPS      = DATAWIDTH'(TAPS_DEF)
)(
  input  logic [DATAWIDTH-1:0] lfsr_i,
  output logic [DATAWIDTH-1:0] next_c_o
);

  always_comb begin
    next_c_o = (lfsr_i >> 1) ^ (lfsr_i[0] ? TAPS : '0);
  end

endmodule

// File: rtl/sc_psrandom_lfsr.sv
// LFSR generator stage: seed load, capture into a stable output register,
// seeding status and a saturating capture counter.
module sc_psrandom_lfsr
  import sc_psrandom_pkg::*;
#(
  parameter int unsigned          DATAWIDTH    = DATAWIDTH_DEF,
  parameter logic [DATAWIDTH-1:0] TAPS         = DATAWIDTH'(TAPS_DEF),
  parameter logic [DATAWIDTH-1:0] SEED_DEFAULT = DATAWIDTH'(SEED_DEF),
  parameter int unsigned          COUNTWIDTH   = COUNTWIDTH_DEF
)(
  input  logic             SC_STATEMACHINE_CLOCK_50,
  input  logic             SC_STATEMACHINE_RESET_InHigh,
  sc_psrandom_lfsr_if.slave bus
);

  localparam logic [COUNTWIDTH-1:0] COUNT_MAX = '1;

  state_e                state_q;
  logic [DATAWIDTH-1:0]  lfsr_q, lfsr_d, lfsr_step;
  logic [DATAWIDTH-1:0]  random_q, random_d;
  logic                  valid_q, valid_d;
  logic [COUNTWIDTH-1:0] count_q, count_d;
  logic                  seed_load, capture;

  sc_psrandom_lfsr_step #(
    .DATAWIDTH (DATAWIDTH),
    .TAPS      (TAPS)
  ) u_step (
    .lfsr_i   (lfsr_q),
    .next_c_o (lfsr_step)
  );

  assign seed_load = ~bus.loadseed_InLow;
  assign capture   = bus.loadseed_InLow & ~bus.loadrand_InLow;

  // Seed load wins over capture and advance; a zero register is forced back to the default.
  always_comb begin
    lfsr_d   = lfsr_q;
    random_d = random_q;
    valid_d  = 1'b0;
    count_d  = count_q;
    if (seed_load) begin
      lfsr_d  = (bus.seed_InBUS == '0) ? SEED_DEFAULT : bus.seed_InBUS;
      count_d = '0;
    end else begin
      if (capture) begin
        random_d = lfsr_q;
        valid_d  = 1'b1;
        count_d  = (count_q == COUNT_MAX) ? count_q : count_q + COUNTWIDTH'(1);
      end
      if (lfsr_q == '0) begin
        lfsr_d = SEED_DEFAULT;
      end else if (bus.run_InHigh) begin
        lfsr_d = lfsr_step;
      end
    end
  end

  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
    if (SC_STATEMACHINE_RESET_InHigh) begin
      state_q  <= ST_UNSEEDED;
      lfsr_q   <= SEED_DEFAULT;
      random_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      if (seed_load) begin
        state_q <= ST_SEEDED;
      end
      lfsr_q   <= lfsr_d;
      random_q <= random_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign bus.random_OutBUS  = random_q;
  assign bus.valid_OutHigh  = valid_q;
  assign bus.seeded_OutHigh = (state_q == ST_SEEDED);
  assign bus.count_OutBUS   = count_q;

endmodule

// File: tb/tb_sc_psrandom_lfsr.sv
// Directed and randomized checks of sc_psrandom_lfsr against a behavioural model.
module tb_sc_psrandom_lfsr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  // Behavioural model state
  int m_lfsr, m_out, m_valid, m_seeded, m_count;

  sc_psrandom_lfsr_if #(.DATAWIDTH(8), .COUNTWIDTH(8)) bus ();

  sc_psrandom_lfsr dut (
    .SC_STATEMACHINE_CLOCK_50     (clk),
    .SC_STATEMACHINE_RESET_InHigh (rst),
    .bus                          (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".random"}, 32'(bus.random_OutBUS),  32'(m_out));
    chk({tag, ".valid"},  32'(bus.valid_OutHigh),  32'(m_valid));
    chk({tag, ".seeded"}, 32'(bus.seeded_OutHigh), 32'(m_seeded));
    chk({tag, ".count"},  32'(bus.count_OutBUS),   32'(m_count));
  endtask

  task automatic model_reset();
    m_lfsr = 1; m_out = 0; m_valid = 0; m_seeded = 0; m_count = 0;
  endtask

  // Galois right-shift step written as arithmetic on an integer
  function automatic int galois(input int x);
    return (x / 2) ^ ((x % 2 == 1) ? 'hB8 : 0);
  endfunction

  task automatic model_edge();
    if (bus.loadseed_InLow === 1'b0) begin
      m_lfsr   = (bus.seed_InBUS == 8'h00) ? 1 : int'(bus.seed_InBUS);
      m_count  = 0;
      m_valid  = 0;
      m_seeded = 1;
    end else begin
      if (bus.loadrand_InLow === 1'b0) begin
        m_out   = m_lfsr;
        m_valid = 1;
        if (m_count < 255) m_count++;
      end else begin
        m_valid = 0;
      end
      if (m_lfsr == 0) m_lfsr = 1;
      else if (bus.run_InHigh) m_lfsr = galois(m_lfsr);
    end
  endtask

  task automatic drive(input logic ls, input logic lr, input logic run, input logic [7:0] seed);
    bus.loadseed_InLow = ls;
    bus.loadrand_InLow = lr;
    bus.run_InHigh     = run;
    bus.seed_InBUS     = seed;
  endtask

  // One clock: model follows the sampled inputs, outputs checked 1 time unit after the edge
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  initial begin
    int first_ret;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;

    // Free run from the default seed, then one capture
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) cycle("run_idle");
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    cycle("cap_default");
    chk("cap_default.const", 32'(bus.random_OutBUS), 32'h17);
    chk("cap_default.cnt1",  32'(bus.count_OutBUS),  32'h01);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    cycle("cap_default.after");

    // Zero seed maps to the default seed
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    cycle("seed_zero");
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) cycle("seed_zero.run");
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cycle("seed_zero.cap");
    chk("seed_zero.const", 32'(bus.random_OutBUS), 32'hB3);

    // Seed load overrides a simultaneous capture
    drive(1'b0, 1'b0, 1'b1, 8'h5A);
    cycle("seed_and_cap");
    chk("seed_and_cap.hold", 32'(bus.random_OutBUS), 32'hB3);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    cycle("seed_and_cap.next");
    chk("seed_and_cap.5a", 32'(bus.random_OutBUS), 32'h5A);

    // Counter saturation over 300 one-cycle strobes
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      cycle("sat.pulse");
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      cycle("sat.gap");
    end
    chk("sat.const", 32'(bus.count_OutBUS), 32'hFF);
    drive(1'b0, 1'b1, 1'b0, 8'h33);
    cycle("sat.clear");
    chk("sat.clear.const", 32'(bus.count_OutBUS), 32'h00);

    // Full period from seed 01, capturing every cycle
    drive(1'b0, 1'b1, 1'b0, 8'h01);
    cycle("period.seed");
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    first_ret = -1;
    for (int i = 0; i < 256; i++) begin
      cycle("period");
      chk("period.nonzero", 32'(bus.random_OutBUS != 8'h00), 32'h1);
      if (i > 0 && bus.random_OutBUS == 8'h01 && first_ret < 0) first_ret = i;
    end
    chk("period.length", 32'(first_ret), 32'd255);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] s;
      s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), s);
      cycle("random");
    end

    // Asynchronous reset between edges
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    cycle("pre_reset");
    #4 rst = 1'b1;
    model_reset();
    #1;
    chk_all("async_reset");
    @(posedge clk);
    #1;
    chk_all("async_reset.hold");
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    cycle("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
